stop_watch_timer: RTL and testbench

//  Elapsed-time counter on the consumer side of stop_watch. Takes the control
//  FSM's running/reset status and counts elapsed time in BCD: MM:SS.t, where t
//  is tenths of a second. Provides a lap-hold freeze of the displayed value and
//  a sticky overflow flag. Drives the display path downstream of stop_watch.

---
 rtl/stop_watch_timer.sv | 228 ++++++++++++++++++++++
 tb/tb_stop_watch_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_timer.sv
// -----------------------------------------------------------------------------
// stop_watch_timer
//
// Elapsed-time counter sitting behind the stop_watch control FSM. While the
// FSM reports "running" a prescaler divides the system clock down to a 0.1 s
// tick, and each tick advances a BCD MM:SS.t count. A lap request freezes the
// displayed value while the live count keeps going, and a sticky flag records
// that the count wrapped past 59:59.9.
//
// Parameters
//   TICK_DIV  clock cycles per 0.1 s tick (>= 2)
//   CNT_W     prescaler width, derived from TICK_DIV
//
// Ports
//   i_clk_h            system clock, rising edge
//   i_sys_rst_l        synchronous active-low system reset
//   i_watch_running_h  count enable from the control FSM
//   i_watch_rst_h      clear-time request from the control FSM
//   i_lap_h            lap request level; each rising edge toggles lap hold
//   o_tenths           displayed tenths of a second (BCD 0-9)
//   o_sec_ones         displayed seconds units (BCD 0-9)
//   o_sec_tens         displayed seconds tens (BCD 0-5)
//   o_min_ones         displayed minutes units (BCD 0-9)
//   o_min_tens         displayed minutes tens (BCD 0-5)
//   o_tick_h           one-cycle pulse each time the count advances
//   o_lap_active_h     display is frozen at the lap capture
//   o_overflow_h       sticky: count wrapped past 59:59.9
// -----------------------------------------------------------------------------
module stop_watch_timer #(
    parameter  int TICK_DIV = 5_000_000,
    localparam int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       i_clk_h,
    input  logic       i_sys_rst_l,
    input  logic       i_watch_running_h,
    input  logic       i_watch_rst_h,
    input  logic       i_lap_h,
    output logic [3:0] o_tenths,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_tick_h,
    output logic       o_lap_active_h,
    output logic       o_overflow_h
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRESC_ZERO = CNT_W'(0);

    // One BCD digit step: returns {carry_out, next_digit}. The digit only
    // moves when carry_in is set; reaching (or somehow exceeding) max_d wraps
    // to zero and carries, so an out-of-range value can never persist.
    function automatic logic [4:0] bcd_step(
        input logic [3:0] d,
        input logic [3:0] max_d,
        input logic       cin
    );
        logic [4:0] r;
        if (!cin) begin
            r = {1'b0, d};
        end else if (d >= max_d) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    // Live count, prescaler and status registers
    logic [CNT_W-1:0] presc_q,      presc_d;
    logic [3:0]       tenths_q,     tenths_d;
    logic [3:0]       sec_ones_q,   sec_ones_d;
    logic [3:0]       sec_tens_q,   sec_tens_d;
    logic [3:0]       min_ones_q,   min_ones_d;
    logic [3:0]       min_tens_q,   min_tens_d;
    logic             tick_q,       tick_d;
    logic             overflow_q,   overflow_d;

    // Lap capture registers and lap edge detector
    logic [3:0]       cap_tenths_q,   cap_tenths_d;
    logic [3:0]       cap_sec_ones_q, cap_sec_ones_d;
    logic [3:0]       cap_sec_tens_q, cap_sec_tens_d;
    logic [3:0]       cap_min_ones_q, cap_min_ones_d;
    logic [3:0]       cap_min_tens_q, cap_min_tens_d;
    logic             lap_q,          lap_d;
    logic             lap_active_q,   lap_active_d;

    // Combinational helpers
    logic [4:0]       tn_step_s;
    logic [4:0]       so_step_s;
    logic [4:0]       st_step_s;
    logic [4:0]       mo_step_s;
    logic [4:0]       mt_step_s;
    logic             tick_now_s;
    logic             lap_edge_s;

    // Carry chain for one 0.1 s increment of the live count
    assign tn_step_s = bcd_step(tenths_q,   4'd9, 1'b1);
    assign so_step_s = bcd_step(sec_ones_q, 4'd9, tn_step_s[4]);
    assign st_step_s = bcd_step(sec_tens_q, 4'd5, so_step_s[4]);
    assign mo_step_s = bcd_step(min_ones_q, 4'd9, st_step_s[4]);
    assign mt_step_s = bcd_step(min_tens_q, 4'd5, mo_step_s[4]);

    assign tick_now_s = i_watch_running_h && (presc_q == PRESC_LAST);
    assign lap_edge_s = i_lap_h & ~lap_q;

    // Next-state logic: watch reset beats counting and lap handling
    always_comb begin
        presc_d        = presc_q;
        tenths_d       = tenths_q;
        sec_ones_d     = sec_ones_q;
        sec_tens_d     = sec_tens_q;
        min_ones_d     = min_ones_q;
        min_tens_d     = min_tens_q;
        tick_d         = 1'b0;
        overflow_d     = overflow_q;
        cap_tenths_d   = cap_tenths_q;
        cap_sec_ones_d = cap_sec_ones_q;
        cap_sec_tens_d = cap_sec_tens_q;
        cap_min_ones_d = cap_min_ones_q;
        cap_min_tens_d = cap_min_tens_q;
        lap_active_d   = lap_active_q;
        lap_d          = i_lap_h;

        if (i_watch_rst_h) begin
            presc_d        = PRESC_ZERO;
            tenths_d       = 4'd0;
            sec_ones_d     = 4'd0;
            sec_tens_d     = 4'd0;
            min_ones_d     = 4'd0;
            min_tens_d     = 4'd0;
            overflow_d     = 1'b0;
            cap_tenths_d   = 4'd0;
            cap_sec_ones_d = 4'd0;
            cap_sec_tens_d = 4'd0;
            cap_min_ones_d = 4'd0;
            cap_min_tens_d = 4'd0;
            lap_active_d   = 1'b0;
        end else begin
            if (tick_now_s) begin
                presc_d    = PRESC_ZERO;
                tick_d     = 1'b1;
                tenths_d   = tn_step_s[3:0];
                sec_ones_d = so_step_s[3:0];
                sec_tens_d = st_step_s[3:0];
                min_ones_d = mo_step_s[3:0];
                min_tens_d = mt_step_s[3:0];
                // Carry out of the minutes-tens digit means 59:59.9 -> 00:00.0
                if (mt_step_s[4]) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
            end else if (i_watch_running_h) begin
                presc_d = presc_q + PRESC_ONE;
            end else begin
                // Paused: prescaler holds so a resumed run keeps its partial tick
                presc_d = presc_q;
            end

            // Capture uses the _q digits, i.e. the value before any same-edge tick
            if (lap_edge_s) begin
                if (!lap_active_q) begin
                    cap_tenths_d   = tenths_q;
                    cap_sec_ones_d = sec_ones_q;
                    cap_sec_tens_d = sec_tens_q;
                    cap_min_ones_d = min_ones_q;
                    cap_min_tens_d = min_tens_q;
                    lap_active_d   = 1'b1;
                end else begin
                    lap_active_d   = 1'b0;
                end
            end else begin
                lap_active_d = lap_active_q;
            end
        end
    end

    // State registers with synchronous active-low system reset
    always_ff @(posedge i_clk_h) begin
        if (!i_sys_rst_l) begin
            presc_q        <= PRESC_ZERO;
            tenths_q       <= 4'd0;
            sec_ones_q     <= 4'd0;
            sec_tens_q     <= 4'd0;
            min_ones_q     <= 4'd0;
            min_tens_q     <= 4'd0;
            tick_q         <= 1'b0;
            overflow_q     <= 1'b0;
            cap_tenths_q   <= 4'd0;
            cap_sec_ones_q <= 4'd0;
            cap_sec_tens_q <= 4'd0;
            cap_min_ones_q <= 4'd0;
            cap_min_tens_q <= 4'd0;
            lap_q          <= 1'b0;
            lap_active_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            tenths_q       <= tenths_d;
            sec_ones_q     <= sec_ones_d;
            sec_tens_q     <= sec_tens_d;
            min_ones_q     <= min_ones_d;
            min_tens_q     <= min_tens_d;
            tick_q         <= tick_d;
            overflow_q     <= overflow_d;
            cap_tenths_q   <= cap_tenths_d;
            cap_sec_ones_q <= cap_sec_ones_d;
            cap_sec_tens_q <= cap_sec_tens_d;
            cap_min_ones_q <= cap_min_ones_d;
            cap_min_tens_q <= cap_min_tens_d;
            lap_q          <= lap_d;
            lap_active_q   <= lap_active_d;
        end
    end

    // Display selects between two register banks, adding no latency
    assign o_tenths       = lap_active_q ? cap_tenths_q   : tenths_q;
    assign o_sec_ones     = lap_active_q ? cap_sec_ones_q : sec_ones_q;
    assign o_sec_tens     = lap_active_q ? cap_sec_tens_q : sec_tens_q;
    assign o_min_ones     = lap_active_q ? cap_min_ones_q : min_ones_q;
    assign o_min_tens     = lap_active_q ? cap_min_tens_q : min_tens_q;
    assign o_tick_h       = tick_q;
    assign o_lap_active_h = lap_active_q;
    assign o_overflow_h   = overflow_q;

endmodule

// File: tb/tb_stop_watch_timer.sv
// -----------------------------------------------------------------------------
// tb_stop_watch_timer
//
// Scoreboard bench. Two instances share one clock:
//   u_dut  (TICK_DIV=4) : reset, run, pause/resume, lap and conflict cases
//   u_wrap (TICK_DIV=2) : runs in parallel through 36001 ticks for the wrap
// Stimulus pushes hand-computed expected outputs into queues; monitors on the
// falling edge pop and compare whenever a tick pulse or a snapshot strobe is
// presented.
// -----------------------------------------------------------------------------
module tb_stop_watch_timer;

    typedef struct {
        string       name;
        logic [22:0] v;   // {mt, mo, st, so, tn, tick, lap, ovf}
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic m_rst_l = 1'b0, m_run = 1'b0, m_wrst = 1'b0, m_lap = 1'b0;
    logic [3:0] m_tn, m_so, m_st, m_mo, m_mt;
    logic m_tk, m_lp, m_ov;
    logic [22:0] m_vec;
    logic m_snap = 1'b0;

    // wrap instance
    logic w_rst_l = 1'b0, w_run = 1'b0, w_wrst = 1'b0, w_lap = 1'b0;
    logic [3:0] w_tn, w_so, w_st, w_mo, w_mt;
    logic w_tk, w_lp, w_ov;
    logic [22:0] w_vec;
    logic w_snap = 1'b0;
    int   wedge = 0;

    exp_t tick_q[$];
    exp_t snap_q[$];
    exp_t wsnap_q[$];
    exp_t m_e, t_e, w_e;

    int vec_cnt = 0;
    int err_cnt = 0;

    stop_watch_timer #(.TICK_DIV(4)) u_dut (
        .i_clk_h(clk), .i_sys_rst_l(m_rst_l), .i_watch_running_h(m_run),
        .i_watch_rst_h(m_wrst), .i_lap_h(m_lap),
        .o_tenths(m_tn), .o_sec_ones(m_so), .o_sec_tens(m_st),
        .o_min_ones(m_mo), .o_min_tens(m_mt), .o_tick_h(m_tk),
        .o_lap_active_h(m_lp), .o_overflow_h(m_ov)
    );

    stop_watch_timer #(.TICK_DIV(2)) u_wrap (
        .i_clk_h(clk), .i_sys_rst_l(w_rst_l), .i_watch_running_h(w_run),
        .i_watch_rst_h(w_wrst), .i_lap_h(w_lap),
        .o_tenths(w_tn), .o_sec_ones(w_so), .o_sec_tens(w_st),
        .o_min_ones(w_mo), .o_min_tens(w_mt), .o_tick_h(w_tk),
        .o_lap_active_h(w_lp), .o_overflow_h(w_ov)
    );

    assign m_vec = {m_mt, m_mo, m_st, m_so, m_tn, m_tk, m_lp, m_ov};
    assign w_vec = {w_mt, w_mo, w_st, w_so, w_tn, w_tk, w_lp, w_ov};

    function automatic exp_t mk(input string n, input logic [3:0] mt, mo, st, so, tn,
                                input logic tk, lp, ov);
        exp_t e;
        e.name = n;
        e.v    = {mt, mo, st, so, tn, tk, lp, ov};
        return e;
    endfunction

    task automatic cmp(input string n, input logic [22:0] got, input logic [22:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got mm:ss.t=%h%h:%h%h.%h tick=%b lap=%b ovf=%b, expected %h%h:%h%h.%h tick=%b lap=%b ovf=%b",
                     n, got[22:19], got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                     exp[22:19], exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic flag(input string n, input int got, input int exp);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    endtask

    // Main monitor: snapshots and tick pulses of u_dut
    always @(negedge clk) begin
        if (m_snap) begin
            if (snap_q.size() == 0) begin
                flag("snap_queue_empty", 0, 1);
            end else begin
                m_e = snap_q.pop_front();
                cmp(m_e.name, m_vec, m_e.v);
            end
        end
        if (m_tk === 1'b1) begin
            if (tick_q.size() == 0) begin
                flag("unexpected_tick", 1, 0);
            end else begin
                t_e = tick_q.pop_front();
                cmp(t_e.name, m_vec, t_e.v);
            end
        end
    end

    // Wrap monitor: snapshots of u_wrap
    always @(negedge clk) begin
        if (w_snap) begin
            if (wsnap_q.size() == 0) begin
                flag("wrap_snap_queue_empty", 0, 1);
            end else begin
                w_e = wsnap_q.pop_front();
                cmp(w_e.name, w_vec, w_e.v);
            end
        end
    end

    task automatic mstep();
        @(posedge clk);
        #1;
        m_snap = 1'b0;
    endtask

    task automatic msnap(input string n, input logic [3:0] mt, mo, st, so, tn,
                         input logic tk, lp, ov);
        snap_q.push_back(mk(n, mt, mo, st, so, tn, tk, lp, ov));
        m_snap = 1'b1;
    endtask

    task automatic push_tick(input string n, input logic [3:0] mt, mo, st, so, tn,
                             input logic lp);
        tick_q.push_back(mk(n, mt, mo, st, so, tn, 1'b1, lp, 1'b0));
    endtask

    task automatic wstep();
        @(posedge clk);
        #1;
        w_snap = 1'b0;
        wedge++;
    endtask

    task automatic wrap_at(input int ticks, input string n, input logic [3:0] mt, mo, st, so, tn,
                           input logic ov);
        while (wedge < 2 * ticks) wstep();
        wsnap_q.push_back(mk(n, mt, mo, st, so, tn, 1'b1, 1'b0, ov));
        w_snap = 1'b1;
    endtask

    task automatic run_main();
        // power-on reset
        mstep(); mstep();
        m_rst_l = 1'b1;
        msnap("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // 40 running cycles -> 10 ticks -> 00:01.0
        m_run = 1'b1;
        for (int k = 1; k <= 9; k++) push_tick($sformatf("run_tick%0d", k), 0, 0, 0, 0, 4'(k), 0);
        push_tick("run_tick10", 0, 0, 0, 1, 0, 0);
        repeat (40) mstep();
        msnap("run_40", 0, 0, 0, 1, 0, 1, 0, 0);

        // watch reset while paused
        m_run = 1'b0; m_wrst = 1'b1;
        mstep();
        m_wrst = 1'b0;
        msnap("watch_rst", 0, 0, 0, 0, 0, 0, 0, 0);

        // pause/resume keeps the partial tick (prescaler = 2 at pause)
        m_run = 1'b1;
        push_tick("pr_tick1", 0, 0, 0, 0, 1, 0);
        repeat (6) mstep();
        m_run = 1'b0;
        repeat (20) mstep();
        msnap("paused", 0, 0, 0, 0, 1, 0, 0, 0);
        m_run = 1'b1;
        push_tick("pr_tick2", 0, 0, 0, 0, 2, 0);
        mstep();
        msnap("resume_1", 0, 0, 0, 0, 1, 0, 0, 0);
        mstep();
        msnap("resume_2", 0, 0, 0, 0, 2, 1, 0, 0);

        // lap capture at 00:00.5, 8 more ticks stay frozen, release shows 00:01.3
        push_tick("lap_pre3", 0, 0, 0, 0, 3, 0);
        push_tick("lap_pre4", 0, 0, 0, 0, 4, 0);
        push_tick("lap_pre5", 0, 0, 0, 0, 5, 0);
        repeat (12) mstep();
        m_lap = 1'b1;
        for (int k = 1; k <= 8; k++) push_tick($sformatf("lap_frozen%0d", k), 0, 0, 0, 0, 5, 1);
        mstep();
        m_lap = 1'b0;
        msnap("lap_capture", 0, 0, 0, 0, 5, 0, 1, 0);
        repeat (31) mstep();
        msnap("lap_hold", 0, 0, 0, 0, 5, 1, 1, 0);
        m_run = 1'b0; m_lap = 1'b1;
        mstep();
        m_lap = 1'b0;
        msnap("lap_release", 0, 0, 0, 1, 3, 0, 0, 0);

        // lap edge on a tick edge captures the pre-increment value 00:01.3
        m_run = 1'b1;
        repeat (3) mstep();
        m_lap = 1'b1;
        push_tick("lap_on_tick_pulse", 0, 0, 0, 1, 3, 1);
        mstep();
        m_lap = 1'b0;
        msnap("lap_on_tick", 0, 0, 0, 1, 3, 1, 1, 0);
        push_tick("lap_frozen_tick", 0, 0, 0, 1, 3, 1);
        repeat (7) mstep();

        // watch reset + running + lap edge + would-be tick on one edge
        m_wrst = 1'b1; m_lap = 1'b1;
        mstep();
        msnap("conflict", 0, 0, 0, 0, 0, 0, 0, 0);
        m_wrst = 1'b0; m_run = 1'b0;
        mstep();
        msnap("conflict_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        m_lap = 1'b0;

        // system reset mid-count clears everything including the prescaler
        m_run = 1'b1;
        push_tick("mid_tick", 0, 0, 0, 0, 1, 0);
        repeat (6) mstep();
        m_lap = 1'b1;
        mstep();
        m_lap = 1'b0; m_rst_l = 1'b0;
        mstep();
        msnap("sysrst_1", 0, 0, 0, 0, 0, 0, 0, 0);
        mstep();
        msnap("sysrst_2", 0, 0, 0, 0, 0, 0, 0, 0);
        m_rst_l = 1'b1;
        push_tick("post_rst_tick", 0, 0, 0, 0, 1, 0);
        repeat (3) mstep();
        msnap("post_rst_3", 0, 0, 0, 0, 0, 0, 0, 0);
        mstep();
        msnap("post_rst_4", 0, 0, 0, 0, 1, 1, 0, 0);
        m_run = 1'b0;
        mstep(); mstep();
    endtask

    task automatic run_wrap();
        wstep(); wstep();
        w_rst_l = 1'b1;
        w_run   = 1'b1;
        wedge   = 0;
        wrap_at(600,   "wrap_01m",   0, 1, 0, 0, 0, 0);
        wrap_at(6000,  "wrap_10m",   1, 0, 0, 0, 0, 0);
        wrap_at(35999, "wrap_top",   5, 9, 5, 9, 9, 0);
        wrap_at(36000, "wrap_zero",  0, 0, 0, 0, 0, 1);
        wrap_at(36001, "wrap_after", 0, 0, 0, 0, 1, 1);
        wstep();
        w_wrst = 1'b1;
        wstep();
        w_wrst = 1'b0; w_run = 1'b0;
        wsnap_q.push_back(mk("wrap_clear", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        w_snap = 1'b1;
        wstep(); wstep();
    endtask

    initial begin
        fork
            run_main();
            run_wrap();
        join
        repeat (4) @(posedge clk);
        #1;
        vec_cnt++;
        if (tick_q.size() != 0) begin
            err_cnt++;
            $display("FAIL missing_ticks: got %0d pending, expected 0", tick_q.size());
        end
        vec_cnt++;
        if (snap_q.size() + wsnap_q.size() != 0) begin
            err_cnt++;
            $display("FAIL unchecked_snaps: got %0d pending, expected 0", snap_q.size() + wsnap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
